fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_pkg.sv | 22 ++
 rtl/baud_gen.sv | 28 ++
 rtl/fifo_uart_tx.sv | 138 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared UART constants, state encodings and helpers
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DBIT       = 8;
  localparam int UART_SB_TICK    = 16;
  localparam int UART_DVSR       = 326;
  localparam int UART_DVSR_BIT   = 9;
  localparam int UART_OVERSAMPLE = 16;

  // Tick counter is 4 bits, widened only when the stop bit needs more than 16 ticks.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > UART_OVERSAMPLE) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - mod-DVSR oversample tick generator with synchronous clear
module baud_gen #(
  parameter int DVSR     = 326,
  parameter int DVSR_BIT = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [DVSR_BIT-1:0] CNT_LAST = DVSR_BIT'(DVSR - 1);

  logic [DVSR_BIT-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DVSR_BIT'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST) && !clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a first-word-fall-through FIFO
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT     = UART_DBIT,
  parameter int SB_TICK  = UART_SB_TICK,
  parameter int DVSR     = UART_DVSR,
  parameter int DVSR_BIT = UART_DVSR_BIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy
);

  localparam int S_W = tick_cnt_width(SB_TICK);
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(UART_OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  uart_state_t     r_state;
  logic [S_W-1:0]  r_s_reg;
  logic [N_W-1:0]  r_n_reg;
  logic [DBIT-1:0] r_b_reg;
  logic            r_tx;
  logic            r_rd;
  logic            r_busy;

  logic            w_tick;
  logic            w_clr;
  logic            w_start;
  logic            w_load;
  logic [DBIT-1:0] w_b_shift;

  assign w_start   = en && !empty;
  assign w_clr     = (r_state == ST_IDLE);
  assign w_b_shift = r_b_reg >> 1;

  // A frame may start from IDLE or straight out of the final stop tick, so
  // back-to-back frames carry no idle cycle between stop and start.
  assign w_load = w_start &&
                  ((r_state == ST_IDLE) ||
                   ((r_state == ST_STOP) && w_tick && (r_s_reg == S_STOP_LAST)));

  baud_gen #(
    .DVSR     (DVSR),
    .DVSR_BIT (DVSR_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s_reg <= '0;
      r_n_reg <= '0;
      r_b_reg <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      if (w_load) begin
        r_state <= ST_START;
        r_b_reg <= r_data;
        r_s_reg <= '0;
        r_n_reg <= '0;
        r_tx    <= 1'b0;
        r_rd    <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
          ST_START: begin
            if (w_tick) begin
              if (r_s_reg == S_BIT_LAST) begin
                r_state <= ST_DATA;
                r_s_reg <= '0;
                r_n_reg <= '0;
                r_tx    <= r_b_reg[0];
              end else begin
                r_s_reg <= r_s_reg + S_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              if (r_s_reg == S_BIT_LAST) begin
                r_s_reg <= '0;
                r_b_reg <= w_b_shift;
                if (r_n_reg == N_LAST) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                end else begin
                  r_n_reg <= r_n_reg + N_W'(1);
                  r_tx    <= w_b_shift[0];
                end
              end else begin
                r_s_reg <= r_s_reg + S_W'(1);
              end
            end
          end
          ST_STOP: begin
            if (w_tick) begin
              if (r_s_reg == S_STOP_LAST) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_s_reg <= r_s_reg + S_W'(1);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd      = r_rd;
  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed/random bench for fifo_uart_tx against a frame-level model
module tb_fifo_uart_tx;

  localparam int DVSR    = 4;
  localparam int BIT_CYC = 16 * DVSR;
  localparam int FRAME16 = 10 * BIT_CYC;
  localparam int STOP32  = 32 * DVSR;
  localparam int S_TX = 0, S_RD = 1, S_BUSY = 2, S_TX32 = 3, S_RD32 = 4, S_BUSY32 = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       en32 = 1'b0;
  logic       empty32 = 1'b1;
  logic [7:0] r_data32 = 8'h00;
  logic       rd, tx, tx_busy;
  logic       rd32, tx32, busy32;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0, t1, viol;
  logic [7:0] d0, d1, d2, d3;
  logic [7:0] rnd [4];

  logic [7:0] q [$];
  logic tx_log [$];
  logic rd_log [$];
  logic busy_log [$];
  logic empty_log [$];
  logic tx32_log [$];
  logic rd32_log [$];
  logic busy32_log [$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(3)) dut (
    .clk(clk), .reset(reset), .en(en), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy)
  );

  fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(DVSR), .DVSR_BIT(3)) dut32 (
    .clk(clk), .reset(reset), .en(en32), .empty(empty32), .r_data(r_data32),
    .rd(rd32), .tx(tx32), .tx_busy(busy32)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic refresh();
    empty  = (q.size() == 0);
    r_data = empty ? 8'h00 : q[0];
  endtask

  task automatic log_now();
    tx_log.push_back(tx);
    rd_log.push_back(rd);
    busy_log.push_back(tx_busy);
    empty_log.push_back(empty);
    tx32_log.push_back(tx32);
    rd32_log.push_back(rd32);
    busy32_log.push_back(busy32);
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    refresh();
    empty_log[cyc] = empty;
  endtask

  // FIFO model pops on the edge that samples rd high; outputs logged 1 time unit after each edge.
  task automatic step();
    logic was_rd, was_rd32;
    was_rd   = rd;
    was_rd32 = rd32;
    @(posedge clk);
    #1;
    if (was_rd && q.size() > 0) void'(q.pop_front());
    if (was_rd32) empty32 = 1'b1;
    cyc++;
    refresh();
    log_now();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic sample(input int which, input int i);
    if (i < 0 || i >= tx_log.size()) return 1'bx;
    case (which)
      S_TX:     return tx_log[i];
      S_RD:     return rd_log[i];
      S_BUSY:   return busy_log[i];
      S_TX32:   return tx32_log[i];
      S_RD32:   return rd32_log[i];
      S_BUSY32: return busy32_log[i];
      default:  return 1'bx;
    endcase
  endfunction

  function automatic int cnt(input int which, input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (sample(which, i) === 1'b1) n++;
    return n;
  endfunction

  // Line level at offset k cycles into a frame: start bit, 8 data bits LSB first, then stop.
  function automatic logic exp_tx(input int k, input logic [7:0] d);
    logic [7:0] sh;
    if (k < BIT_CYC) return 1'b0;
    if (k < 9 * BIT_CYC) begin
      sh = d >> ((k - BIT_CYC) / BIT_CYC);
      return sh[0];
    end
    return 1'b1;
  endfunction

  task automatic chk_frame(input string tag, input int fs, input logic [7:0] d, input bit sel32);
    int stop_cyc, lo, hi, nbad, len;
    stop_cyc = sel32 ? STOP32 : BIT_CYC;
    for (int b = 0; b < 10; b++) begin
      lo = fs + b * BIT_CYC;
      hi = (b == 9) ? lo + stop_cyc - 1 : lo + BIT_CYC - 1;
      nbad = 0;
      for (int i = lo; i <= hi; i++)
        if (sample(sel32 ? S_TX32 : S_TX, i) !== exp_tx(i - fs, d)) nbad++;
      chk($sformatf("%s bit%0d wrong cycles", tag, b), nbad, 0);
    end
    len = 9 * BIT_CYC + stop_cyc;
    chk($sformatf("%s busy cycles", tag), cnt(sel32 ? S_BUSY32 : S_BUSY, fs, fs + len - 1), len);
    chk1($sformatf("%s rd at start", tag), sample(sel32 ? S_RD32 : S_RD, fs), 1'b1);
  endtask

  initial begin
    log_now();
    run(3);
    chk1("reset tx", tx, 1'b1);
    chk1("reset rd", rd, 1'b0);
    chk1("reset busy", tx_busy, 1'b0);
    chk1("reset tx32", tx32, 1'b1);
    reset = 1'b0;
    run(2);
    chk1("idle tx", tx, 1'b1);
    chk1("idle busy", tx_busy, 1'b0);

    push(8'hA5);
    en = 1'b1;
    t0 = cyc + 1;
    run(FRAME16 + 20);
    chk_frame("a5", t0, 8'hA5, 1'b0);
    chk("a5 rd pulses", cnt(S_RD, t0 - 1, cyc), 1);
    chk("a5 busy after", cnt(S_BUSY, t0 + FRAME16, cyc), 0);

    push(8'h01);
    push(8'h80);
    t0 = cyc + 1;
    run(2 * FRAME16 + 20);
    chk_frame("b2b0", t0, 8'h01, 1'b0);
    chk_frame("b2b1", t0 + FRAME16, 8'h80, 1'b0);
    chk("b2b rd pulses", cnt(S_RD, t0, cyc), 2);
    chk("b2b busy after", cnt(S_BUSY, t0 + 2 * FRAME16, cyc), 0);

    t0 = cyc + 1;
    run(2000);
    chk("empty rd", cnt(S_RD, t0, cyc), 0);
    chk("empty busy", cnt(S_BUSY, t0, cyc), 0);
    chk("empty tx high", cnt(S_TX, t0, cyc), 2000);

    d0 = 8'($urandom);
    d1 = 8'($urandom);
    push(d0);
    push(d1);
    t0 = cyc + 1;
    run(t0 + 100 - cyc);
    en = 1'b0;
    run(t0 + FRAME16 + 200 - cyc);
    chk_frame("endrop", t0, d0, 1'b0);
    chk("endrop rd pulses", cnt(S_RD, t0, cyc), 1);
    chk("endrop queued words", q.size(), 1);
    chk("endrop busy after", cnt(S_BUSY, t0 + FRAME16, cyc), 0);
    en = 1'b1;
    t1 = cyc + 1;
    run(FRAME16 + 20);
    chk_frame("endrop resume", t1, d1, 1'b0);

    d2 = 8'($urandom);
    d3 = 8'($urandom);
    push(d2);
    push(d3);
    t0 = cyc + 1;
    run(t0 + 4 * BIT_CYC + 24 - cyc);
    chk1("rst pre tx bit3", sample(S_TX, cyc), exp_tx(cyc - t0, d2));
    chk1("rst pre busy", tx_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rst tx", tx, 1'b1);
    chk1("rst rd", rd, 1'b0);
    chk1("rst busy", tx_busy, 1'b0);
    run(2);
    reset = 1'b0;
    t1 = cyc + 1;
    run(FRAME16 + 20);
    chk_frame("post reset", t1, d3, 1'b0);
    chk("post reset rd pulses", cnt(S_RD, t0 + 1, cyc), 1);
    chk("post reset queue", q.size(), 0);

    d0 = 8'($urandom);
    r_data32 = d0;
    empty32 = 1'b0;
    en32 = 1'b1;
    t0 = cyc + 1;
    run(9 * BIT_CYC + STOP32 + 20);
    chk_frame("sb32", t0, d0, 1'b1);
    chk("sb32 rd pulses", cnt(S_RD32, t0, cyc), 1);
    chk("sb32 busy after", cnt(S_BUSY32, t0 + 9 * BIT_CYC + STOP32, cyc), 0);

    for (int i = 0; i < 4; i++) begin
      rnd[i] = 8'($urandom);
      push(rnd[i]);
    end
    t0 = cyc + 1;
    run(4 * FRAME16 + 20);
    for (int i = 0; i < 4; i++)
      chk_frame($sformatf("rnd%0d", i), t0 + i * FRAME16, rnd[i], 1'b0);
    chk("rnd rd pulses", cnt(S_RD, t0, cyc), 4);

    viol = 0;
    for (int i = 0; i < rd_log.size(); i++)
      if (rd_log[i] === 1'b1 && empty_log[i] === 1'b1) viol++;
    chk("rd while empty", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
